// File: rtl/heap_pop_drain.sv
// heap_pop_drain: drains a preloaded signed min-heap in ascending order,
// restoring the heap with a one-level-per-cycle sift-down between outputs.
module heap_pop_drain #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 32,
  parameter int SZW   = 16
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [DEPTH*WIDTH-1:0]   load_heap,
  input  logic [SZW-1:0]           load_size,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_EMIT = 2'd1, S_SIFT = 2'd2;
  logic [1:0]              r_state;
  logic signed [WIDTH-1:0] r_heap [DEPTH];
  logic [SZW-1:0]          r_sz, r_idx;
  logic [SZW-1:0]          w_l, w_r, w_szm1, w_ld_sz;
  logic [AW-1:0]           w_pi, w_li, w_ri, w_ci, w_lasti;
  logic                    w_has_l, w_has_r, w_sel_l, w_sel_r;
  logic signed [WIDTH-1:0] w_pv, w_lv, w_rv, w_cv;
  always_comb begin
    w_l     = (r_idx << 1) + SZW'(1);
    w_r     = w_l + SZW'(1);
    w_szm1  = r_sz - SZW'(1);
    w_pi    = r_idx[AW-1:0];
    w_li    = w_l[AW-1:0];
    w_ri    = w_r[AW-1:0];
    w_lasti = w_szm1[AW-1:0];
    w_has_l = w_l < r_sz;
    w_has_r = w_r < r_sz;
    w_pv    = r_heap[w_pi];
    w_lv    = w_has_l ? r_heap[w_li] : '0;
    w_rv    = w_has_r ? r_heap[w_ri] : '0;
    // strict compares keep the parent on ties, and the left child over the right
    w_sel_l = w_has_l && (w_lv < w_pv);
    w_sel_r = w_has_r && (w_rv < (w_sel_l ? w_lv : w_pv));
    w_ci    = w_sel_r ? w_ri : w_li;
    w_cv    = w_sel_r ? w_rv : w_lv;
    w_ld_sz = (load_size > SZW'(DEPTH)) ? SZW'(DEPTH) : load_size;
  end
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_state <= S_IDLE;
      r_sz    <= '0;
      r_idx   <= '0;
      for (int k = 0; k < DEPTH; k++) r_heap[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (load_valid) begin
          for (int k = 0; k < DEPTH; k++) r_heap[k] <= load_heap[(DEPTH-1-k)*WIDTH +: WIDTH];
          r_sz    <= w_ld_sz;
          r_idx   <= '0;
          r_state <= (w_ld_sz == '0) ? S_IDLE : S_EMIT;
        end
        S_EMIT: if (out_ready) begin
          r_heap[0] <= r_heap[w_lasti];
          r_sz      <= w_szm1;
          r_idx     <= '0;
          r_state   <= (w_szm1 == '0) ? S_IDLE : S_SIFT;
        end
        S_SIFT: if (w_sel_l || w_sel_r) begin
          r_heap[w_pi] <= w_cv;
          r_heap[w_ci] <= w_pv;
          r_idx        <= SZW'(w_ci);
        end else begin
          r_state <= S_EMIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign load_ready = system1000_rstn && (r_state == S_IDLE);
  assign out_valid  = r_state == S_EMIT;
  assign out_data   = out_valid ? r_heap[0] : '0;
  assign out_last   = out_valid && (r_sz == SZW'(1));
  assign busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_heap_pop_drain.sv
// tb_heap_pop_drain: directed vector table plus hand sequences for stall, empty load and mid-sift reset.
module tb_heap_pop_drain;
  typedef struct packed {
    logic [159:0] h;
    logic [15:0]  sz;
    logic [3:0]   stall;
    logic [3:0]   n;
    logic [159:0] e;
  } vec_t;
  logic clk = 0, rstn = 1, load_valid = 0, out_ready = 0;
  logic [159:0] load_heap = '0;
  logic [15:0]  load_size = '0;
  logic load_ready, out_valid, out_last, busy;
  logic signed [31:0] out_data;
  int n_cmp = 0, n_err = 0;
  vec_t vecs [7];
  always #5 clk = ~clk;
  heap_pop_drain #(.DEPTH(5), .WIDTH(32), .SZW(16)) dut (
    .system1000(clk), .system1000_rstn(rstn),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_heap(load_heap), .load_size(load_size),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );
  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [159:0] pk(input int a, input int b, input int c, input int d, input int e);
    return {a, b, c, d, e};
  endfunction
  function automatic logic signed [31:0] sl(input logic [159:0] v, input int i);
    return v[(4-i)*32 +: 32];
  endfunction
  task automatic load(input logic [159:0] h, input logic [15:0] s);
    load_heap = h;
    load_size = s;
    load_valid = 1;
    @(negedge clk);
    load_valid = 0;
  endtask
  task automatic run(input vec_t v, input string tag);
    int w;
    chk({tag, ":ready"}, load_ready, 1);
    out_ready = (v.stall == 0);
    load(v.h, v.sz);
    chk({tag, ":lat"}, out_valid, 1);
    for (int i = 0; i < int'(v.n); i++) begin
      w = 0;
      while (!out_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (!out_valid) begin
        chk($sformatf("%s:timeout%0d", tag, i), out_valid, 1);
        return;
      end
      chk($sformatf("%s:data%0d", tag, i), out_data, sl(v.e, i));
      chk($sformatf("%s:last%0d", tag, i), out_last, (i == int'(v.n) - 1) ? 1 : 0);
      if (i == 0 && v.stall != 0) begin
        repeat (int'(v.stall)) begin
          @(negedge clk);
          chk({tag, ":hold_valid"}, out_valid, 1);
          chk({tag, ":hold_data"}, out_data, sl(v.e, 0));
        end
        out_ready = 1;
      end
      @(negedge clk);
      chk($sformatf("%s:drop%0d", tag, i), out_valid, 0);
    end
    chk({tag, ":idle"}, load_ready, 1);
    chk({tag, ":notbusy"}, busy, 0);
  endtask
  initial begin
    int w;
    vecs[0] = '{h: pk(1, 3, 2, 7, 5),    sz: 5, stall: 0, n: 5, e: pk(1, 2, 3, 5, 7)};
    vecs[1] = '{h: pk(1, 3, 2, 7, 5),    sz: 5, stall: 4, n: 5, e: pk(1, 2, 3, 5, 7)};
    vecs[2] = '{h: pk(-8, -3, 4, 0, 2),  sz: 5, stall: 0, n: 5, e: pk(-8, -3, 0, 2, 4)};
    vecs[3] = '{h: pk(4, 6, 9, 7, 8),    sz: 9, stall: 0, n: 5, e: pk(4, 6, 7, 8, 9)};
    vecs[4] = '{h: pk(2, 2, 2, 5, 5),    sz: 5, stall: 0, n: 5, e: pk(2, 2, 2, 5, 5)};
    vecs[5] = '{h: pk(5, 9, 7, 0, 0),    sz: 3, stall: 0, n: 3, e: pk(5, 7, 9, 0, 0)};
    vecs[6] = '{h: pk(42, 1, 1, 1, 1),   sz: 1, stall: 0, n: 1, e: pk(42, 0, 0, 0, 0)};
    #1 rstn = 0;
    #1;
    chk("rst:load_ready", load_ready, 0);
    chk("rst:out_valid", out_valid, 0);
    chk("rst:out_data", out_data, 0);
    chk("rst:out_last", out_last, 0);
    chk("rst:busy", busy, 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("rel:load_ready", load_ready, 1);
    for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("v%0d", i));
    load(pk(3, 4, 5, 6, 7), 0);
    repeat (3) begin
      chk("empty:out_valid", out_valid, 0);
      chk("empty:load_ready", load_ready, 1);
      chk("empty:busy", busy, 0);
      @(negedge clk);
    end
    out_ready = 1;
    load(pk(1, 3, 2, 7, 5), 5);
    chk("rstop:first", out_data, 1);
    @(negedge clk);
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("rstop:second", out_data, 2);
    @(negedge clk);
    chk("rstop:sift_busy", busy, 1);
    chk("rstop:sift_valid", out_valid, 0);
    #2 rstn = 0;
    #1;
    chk("rstop:busy", busy, 0);
    chk("rstop:valid", out_valid, 0);
    chk("rstop:ready", load_ready, 0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    repeat (2) begin
      chk("rstop:no_output", out_valid, 0);
      @(negedge clk);
    end
    run(vecs[0], "after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
